// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding for the transmitter and receiver.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
`endif

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic START_BIT_VAL   = 1'b0;
  localparam logic STOP_BIT_VAL    = 1'b1;
  localparam logic IDLE_LINE_VAL   = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clk cycles while run is high, pulses bit_done on the
// last cycle of each bit and wraps to zero; held at zero while run is low.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_done = run && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, LSB-first serial output with start/stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int BIT_W = $clog2(FRAME_DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  uart_state_t          state, state_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 bit_done;
  logic                 accept;
  logic                 tx_next;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = tx_valid && tx_ready;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (busy),
    .bit_done (bit_done)
  );

  // tx is registered from the current state, so the line lags the FSM by one
  // cycle: the start bit appears on the edge after acceptance.
  always_comb begin
    state_next = state;
    tx_next    = IDLE_LINE_VAL;
    case (state)
      IDLE: begin
        if (accept) state_next = START;
      end
      START: begin
        tx_next = START_BIT_VAL;
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        tx_next = shift_reg[0];
        if (bit_done && (bit_cnt == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_next = parity_bit;
        if (bit_done) state_next = STOP;
      end
`endif
      STOP: begin
        tx_next = STOP_BIT_VAL;
        if (bit_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= IDLE_LINE_VAL;
      shift_reg <= '0;
      bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state <= state_next;
      tx    <= tx_next;
      if (accept) begin
        shift_reg <= tx_data;
`ifdef UART_TX_PARITY_EN
        parity_bit <= ^tx_data;
`endif
      end else if ((state == DATA) && bit_done) begin
        shift_reg <= shift_reg >> 1;
      end
      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (bit_done) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of sent bytes checked against frames
// captured from the serial line, at CLKS_PER_BIT=8 and CLKS_PER_BIT=2.
module tb_uart_tx;

  localparam int CPB0 = 8;
  localparam int CPB1 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d0, d1;
  logic       v0, v1;
  logic       r0, r1, t0, t1, b0, b1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  sb[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB0), .DATA_BITS(8)) u0 (
    .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v0),
    .tx_ready(r0), .tx(t0), .busy(b0)
  );

  uart_tx #(.CLKS_PER_BIT(CPB1), .DATA_BITS(8)) u1 (
    .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1),
    .tx_ready(r1), .tx(t1), .busy(b1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic line_of(input int inst);
    return (inst == 1) ? t1 : t0;
  endfunction

  function automatic logic ready_of(input int inst);
    return (inst == 1) ? r1 : r0;
  endfunction

  // Drive one byte for one cycle; the acceptance edge is the tick inside.
  task automatic send(input int inst, input logic [7:0] b, input bit expect_frame);
    check("ready_before_send", 32'(ready_of(inst)), 32'd1);
    if (inst == 1) begin d1 = b; v1 = 1'b1; end
    else           begin d0 = b; v0 = 1'b1; end
    if (expect_frame) sb.push_back(b);
    tick();
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic rx_frame(input int inst, input int cpb);
    int unsigned waited = 0;
    int unsigned unstable = 0;
    int unsigned rdy_hi = 0;
    logic [10:0] fr = '0;
    logic [10:0] exp_fr;
    logic [7:0]  exp;
    logic        first;
    while (line_of(inst) !== 1'b0 && waited < 200) begin
      waited++;
      tick();
    end
    check("sb_level", 32'(sb.size() > 0), 32'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    check("start_latency", waited, 32'd1);
    if (waited >= 200) return;
    for (int b = 0; b < NBITS; b++) begin
      first = line_of(inst);
      fr[b] = first;
      for (int c = 0; c < cpb; c++) begin
        if (line_of(inst) !== first) unstable++;
        if (ready_of(inst) && !(b == NBITS - 1 && c == cpb - 1)) rdy_hi++;
        tick();
      end
    end
`ifdef UART_TX_PARITY_EN
    exp_fr = {1'b1, ^exp, exp, 1'b0};
`else
    exp_fr = {1'b0, 1'b1, exp, 1'b0};
`endif
    check("frame_bits", 32'(fr), 32'(exp_fr));
    check("bit_hold", unstable, 32'd0);
    check("ready_low_in_frame", rdy_hi, 32'd0);
  endtask

  initial begin
    int unsigned bad;
    rst = 1'b1;
    d0 = 8'hFF; d1 = 8'hFF;
    v0 = 1'b1;  v1 = 1'b1;
    repeat (3) tick();
    check("rst_tx", 32'(t0), 32'd1);
    check("rst_ready", 32'(r0), 32'd1);
    check("rst_busy", 32'(b0), 32'd0);
    check("rst_tx_cpb2", 32'(t1), 32'd1);
    check("rst_busy_cpb2", 32'(b1), 32'd0);
    v0 = 1'b0; v1 = 1'b0;
    rst = 1'b0;

    // 0xA5 accepted on the first edge after reset release
    send(0, 8'hA5, 1'b1);
    rx_frame(0, CPB0);
    check("ready_after_frame", 32'(r0), 32'd1);
    check("busy_after_frame", 32'(b0), 32'd0);
    check("idle_line", 32'(t0), 32'd1);
    tick();

    // tx_valid held high: 0x00 then 0xFF back to back with a one-cycle gap
    d0 = 8'h00; v0 = 1'b1;
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    tick();
    d0 = 8'hFF;
    rx_frame(0, CPB0);
    v0 = 1'b0;
    rx_frame(0, CPB0);
    check("ready_after_b2b", 32'(r0), 32'd1);
    tick();

    // tx_data changes mid-frame must not alter the frame in flight
    send(0, 8'h55, 1'b1);
    fork
      rx_frame(0, CPB0);
      begin
        repeat (20) tick();
        d0 = 8'h3C;
      end
    join
    tick();

`ifdef UART_TX_PARITY_EN
    send(0, 8'hA5, 1'b1);
    rx_frame(0, CPB0);
    tick();
    send(0, 8'h07, 1'b1);
    rx_frame(0, CPB0);
    tick();
`endif

    // short bit period
    send(1, 8'h80, 1'b1);
    rx_frame(1, CPB1);
    check("ready_after_cpb2", 32'(r1), 32'd1);
    tick();

    // reset mid-frame: 0xC3 has data bit 3 = 0 on the line at cycle 35
    send(0, 8'hC3, 1'b0);
    repeat (34) tick();
    check("pre_reset_line", 32'(t0), 32'd0);
    check("pre_reset_busy", 32'(b0), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(t0), 32'd1);
    check("async_rst_ready", 32'(r0), 32'd1);
    check("async_rst_busy", 32'(b0), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    repeat (12 * CPB0) begin
      tick();
      if (t0 !== 1'b1 || b0 !== 1'b0) bad++;
    end
    check("no_frame_after_reset", bad, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: the transmit-side counterpart of the team's 8x-clock-per-bit receiver.
- Accepts a byte over a valid/ready handshake and serialises it on `tx`, LSB first.
- Frame: 1 start bit, 8 data bits, optional parity bit, 1 stop bit.
- Each bit is held for CLKS_PER_BIT clk cycles, matching the receiver's bit timing (8 clocks/bit).

Parameters:
- CLKS_PER_BIT, 8: clk cycles per serial bit; legal range 2..256.
- DATA_BITS, 8: data bits per frame; fixed at 8 for this revision.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to send; sampled only on acceptance.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line; idle high; registered output.
- busy  output  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Reset values (asynchronous): tx=1, tx_ready=1, busy=0, state=IDLE, bit counter=0, clock counter=0, shift register=0.
- States and transitions:
  - IDLE: tx=1, tx_ready=1.
    - Acceptance is tx_valid & tx_ready at a clk edge.
    - On acceptance: latch tx_data into the shift register, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift_reg[0] for CLKS_PER_BIT cycles per bit; shift right at each bit end.
    - After 8 bits, go to PARITY (feature on) or STOP (feature off).
  - PARITY: tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: tx falls on the first clk edge after the acceptance edge.
- Frame length: 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- tx_ready is 0 in every non-IDLE state.
  - The earliest next acceptance is the IDLE cycle after STOP completes.
  - Minimum frame-to-frame period is therefore frame length + 1 cycle.
- Clock counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit end.
  - Width is $clog2(CLKS_PER_BIT).
  - Holds at 0 in IDLE.
- Bit counter: 0..7 in DATA only; cleared on entry to DATA.
- tx_data changes while not accepting are ignored; the frame in flight is never altered.
- tx_valid held high continuously gives back-to-back frames separated by exactly 1 idle cycle at tx=1.
- Reset asserted mid-frame:
  - tx returns to 1 immediately and the frame is abandoned, with no completion.
  - After release, the next byte requires a new handshake.
- tx_valid asserted during reset has no effect; the first acceptance is possible on the first edge after rst deasserts.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is present; the parity bit is sent between the data bits and the stop bit.
  - Parity bit = XOR of the 8 latched data bits (even parity).
  - Frame is 11 bits.
- Undefined:
  - No PARITY state and no parity logic; frame is 10 bits.
  - State encoding excludes PARITY.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - FRAME_DATA_BITS=8;
  - START_BIT_VAL=0, STOP_BIT_VAL=1, IDLE_LINE_VAL=1.
- The same package is used by the receiver-side constants.
- Sub-module uart_bit_timer:
  - inputs: clk, rst, run;
  - output: bit_done, a one-cycle pulse when the count reaches CLKS_PER_BIT-1;
  - reusable by the receiver.

Test Plan:
- CLKS_PER_BIT=8, parity off; send 0xA5 → tx = 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; 80 cycles total; tx_ready=0 throughout, then 1.
- tx_valid held high with bytes 0x00 then 0xFF → two frames; exactly 1 cycle of tx=1 between the stop of the first and the start of the second; second frame data bits all 1.
- Change tx_data to 0x3C at cycle 20 of a 0x55 frame → the serialised data is still 0x55.
- Assert rst at cycle 35 of a frame → tx=1, tx_ready=1, busy=0 asynchronously; with tx_valid=0 after release, tx stays 1.
- UART_TX_PARITY_EN defined:
  - send 0xA5 → parity bit 0; 88-cycle frame;
  - send 0x07 → parity bit 1.
- CLKS_PER_BIT=2; send 0x80 → 20-cycle frame; the last data bit is 1 for 2 cycles before a 2-cycle stop.
